// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter sharing one simple-bus slave; one transaction outstanding at a time.
// Latency 3 cycles Req->Ack; masters are backpressured by holding Req until their one-cycle Ack.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_M0_Req,
  input  logic              i_M0_Wr,
  input  logic [ADDR_W-1:0] i_M0_Addr,
  input  logic [DATA_W-1:0] i_M0_WData,
  output logic              o_M0_Ack,
  output logic [DATA_W-1:0] o_M0_RData,
  output logic              o_M0_Err,
  input  logic              i_M1_Req,
  input  logic              i_M1_Wr,
  input  logic [ADDR_W-1:0] i_M1_Addr,
  input  logic [DATA_W-1:0] i_M1_WData,
  output logic              o_M1_Ack,
  output logic [DATA_W-1:0] o_M1_RData,
  output logic              o_M1_Err,
  output logic              o_WEnable,
  output logic [ADDR_W-1:0] o_WAddr,
  output logic [DATA_W-1:0] o_WData,
  output logic              o_REnable,
  output logic [ADDR_W-1:0] o_RAddr,
  input  logic [DATA_W-1:0] i_RData,
  input  logic              i_Err,
  output logic [1:0]        o_Grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t r_State;
  logic   r_Last;  // index of the master granted most recently
  logic   r_Wr;

  logic              w_AnyReq;
  logic              w_Pick1;
  logic              w_SelWr;
  logic [ADDR_W-1:0] w_SelAddr;
  logic [DATA_W-1:0] w_SelWData;

  // M1 wins when alone, or on a tie when M0 was served last
  assign w_AnyReq   = i_M0_Req | i_M1_Req;
  assign w_Pick1    = i_M1_Req & (~i_M0_Req | ~r_Last);
  assign w_SelWr    = w_Pick1 ? i_M1_Wr    : i_M0_Wr;
  assign w_SelAddr  = w_Pick1 ? i_M1_Addr  : i_M0_Addr;
  assign w_SelWData = w_Pick1 ? i_M1_WData : i_M0_WData;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State    <= IDLE;
      r_Last     <= 1'b1;
      r_Wr       <= 1'b0;
      o_Grant    <= 2'b00;
      o_WEnable  <= 1'b0;
      o_REnable  <= 1'b0;
      o_WAddr    <= '0;
      o_WData    <= '0;
      o_RAddr    <= '0;
      o_M0_Ack   <= 1'b0;
      o_M1_Ack   <= 1'b0;
      o_M0_RData <= '0;
      o_M1_RData <= '0;
      o_M0_Err   <= 1'b0;
      o_M1_Err   <= 1'b0;
    end else begin
      o_M0_Ack <= 1'b0;
      o_M1_Ack <= 1'b0;
      case (r_State)
        IDLE: begin
          if (w_AnyReq) begin
            r_Wr    <= w_SelWr;
            r_Last  <= w_Pick1;
            o_Grant <= w_Pick1 ? 2'b10 : 2'b01;
            // strobe is registered here so it is high exactly during ISSUE
            if (w_SelWr) begin
              o_WEnable <= 1'b1;
              o_WAddr   <= w_SelAddr;
              o_WData   <= w_SelWData;
            end else begin
              o_REnable <= 1'b1;
              o_RAddr   <= w_SelAddr;
            end
            r_State <= ISSUE;
          end
        end
        ISSUE: begin
          o_WEnable <= 1'b0;
          o_REnable <= 1'b0;
          r_State   <= RESP;
        end
        RESP: begin
          if (o_Grant[1]) begin
            o_M1_RData <= r_Wr ? '0 : i_RData;
            o_M1_Err   <= i_Err;
            o_M1_Ack   <= 1'b1;
          end else begin
            o_M0_RData <= r_Wr ? '0 : i_RData;
            o_M0_Err   <= i_Err;
            o_M0_Ack   <= 1'b1;
          end
          o_Grant <= 2'b00;
          r_State <= IDLE;
        end
        default: begin
          o_WEnable <= 1'b0;
          o_REnable <= 1'b0;
          o_Grant   <= 2'b00;
          r_State   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed self-checking bench for gpio_bus_arbiter.
module tb_gpio_bus_arbiter;
  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_M0_Req = 0, i_M0_Wr = 0, i_M1_Req = 0, i_M1_Wr = 0;
  logic [31:0] i_M0_Addr = 0, i_M0_WData = 0, i_M1_Addr = 0, i_M1_WData = 0;
  logic        o_M0_Ack, o_M0_Err, o_M1_Ack, o_M1_Err;
  logic [31:0] o_M0_RData, o_M1_RData;
  logic        o_WEnable, o_REnable;
  logic [31:0] o_WAddr, o_WData, o_RAddr;
  logic [31:0] i_RData = 0;
  logic        i_Err = 0;
  logic [1:0]  o_Grant;

  int total = 0;
  int bad = 0;

  gpio_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n),
    .i_M0_Req(i_M0_Req), .i_M0_Wr(i_M0_Wr), .i_M0_Addr(i_M0_Addr), .i_M0_WData(i_M0_WData),
    .o_M0_Ack(o_M0_Ack), .o_M0_RData(o_M0_RData), .o_M0_Err(o_M0_Err),
    .i_M1_Req(i_M1_Req), .i_M1_Wr(i_M1_Wr), .i_M1_Addr(i_M1_Addr), .i_M1_WData(i_M1_WData),
    .o_M1_Ack(o_M1_Ack), .o_M1_RData(o_M1_RData), .o_M1_Err(o_M1_Err),
    .o_WEnable(o_WEnable), .o_WAddr(o_WAddr), .o_WData(o_WData),
    .o_REnable(o_REnable), .o_RAddr(o_RAddr),
    .i_RData(i_RData), .i_Err(i_Err), .o_Grant(o_Grant)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst_n = 1'b0;
    tick();
    tick();
    i_Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    tick();
    total++; if ({o_M0_Ack, o_M1_Ack} !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", {o_M0_Ack, o_M1_Ack}); end
    total++; if ({o_WEnable, o_REnable} !== 2'b00) begin bad++; $display("FAIL reset_en got=%b exp=00", {o_WEnable, o_REnable}); end
    total++; if (o_Grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", o_Grant); end
    total++; if ({o_WAddr, o_WData, o_RAddr} !== 96'd0) begin bad++; $display("FAIL reset_slave_bus got=%h exp=0", {o_WAddr, o_WData, o_RAddr}); end
    total++; if ({o_M0_RData, o_M1_RData, o_M0_Err, o_M1_Err} !== 66'd0) begin bad++; $display("FAIL reset_master_out got=%h exp=0", {o_M0_RData, o_M1_RData, o_M0_Err, o_M1_Err}); end
    i_Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_m0_write();
    i_M0_Req = 1; i_M0_Wr = 1; i_M0_Addr = 32'd1; i_M0_WData = 32'h5A; i_Err = 0; i_RData = 32'hFFFF;
    tick();
    total++; if ({o_WEnable, o_REnable} !== 2'b10) begin bad++; $display("FAIL wr_issue_en got=%b exp=10", {o_WEnable, o_REnable}); end
    total++; if (o_WAddr !== 32'd1 || o_WData !== 32'h5A) begin bad++; $display("FAIL wr_issue_bus got=%h/%h exp=1/5a", o_WAddr, o_WData); end
    total++; if (o_Grant !== 2'b01) begin bad++; $display("FAIL wr_grant got=%b exp=01", o_Grant); end
    tick();
    total++; if ({o_WEnable, o_REnable, o_M0_Ack} !== 3'b000) begin bad++; $display("FAIL wr_resp_cycle got=%b exp=000", {o_WEnable, o_REnable, o_M0_Ack}); end
    tick();
    total++; if ({o_M0_Ack, o_M1_Ack} !== 2'b10) begin bad++; $display("FAIL wr_ack got=%b exp=10", {o_M0_Ack, o_M1_Ack}); end
    total++; if (o_M0_Err !== 1'b0 || o_M0_RData !== 32'd0) begin bad++; $display("FAIL wr_resp got err=%b rdata=%h exp err=0 rdata=0", o_M0_Err, o_M0_RData); end
    total++; if (o_Grant !== 2'b00) begin bad++; $display("FAIL wr_grant_clear got=%b exp=00", o_Grant); end
    i_M0_Req = 0;
    tick();
    total++; if (o_M0_Ack !== 1'b0) begin bad++; $display("FAIL wr_ack_single got=%b exp=0", o_M0_Ack); end
  endtask

  task automatic test_m1_read();
    i_M1_Req = 1; i_M1_Wr = 0; i_M1_Addr = 32'd2; i_RData = 32'h0000000C; i_Err = 0;
    tick();
    total++; if ({o_WEnable, o_REnable} !== 2'b01) begin bad++; $display("FAIL rd_issue_en got=%b exp=01", {o_WEnable, o_REnable}); end
    total++; if (o_RAddr !== 32'd2) begin bad++; $display("FAIL rd_addr got=%h exp=2", o_RAddr); end
    total++; if (o_WAddr !== 32'd1) begin bad++; $display("FAIL rd_waddr_hold got=%h exp=1", o_WAddr); end
    tick();
    tick();
    total++; if ({o_M0_Ack, o_M1_Ack} !== 2'b01) begin bad++; $display("FAIL rd_ack got=%b exp=01", {o_M0_Ack, o_M1_Ack}); end
    total++; if (o_M1_RData !== 32'h0C || o_M1_Err !== 1'b0) begin bad++; $display("FAIL rd_data got=%h err=%b exp=c err=0", o_M1_RData, o_M1_Err); end
    i_M1_Req = 0;
    tick();
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_grant;
    do_reset();
    i_M0_Req = 1; i_M0_Wr = 1; i_M0_Addr = 32'h10; i_M0_WData = 32'h11;
    i_M1_Req = 1; i_M1_Wr = 0; i_M1_Addr = 32'h20; i_RData = 32'hBEEF; i_Err = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_grant = (i % 3 == 0) ? 2'b00 : ((((i - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10);
      total++; if (o_Grant !== exp_grant) begin bad++; $display("FAIL arb_grant c%0d got=%b exp=%b", i, o_Grant, exp_grant); end
      total++; if (o_M0_Ack !== (i == 3 || i == 9)) begin bad++; $display("FAIL arb_ack0 c%0d got=%b", i, o_M0_Ack); end
      total++; if (o_M1_Ack !== (i == 6 || i == 12)) begin bad++; $display("FAIL arb_ack1 c%0d got=%b", i, o_M1_Ack); end
      total++; if (o_WEnable !== (i % 6 == 1) || o_REnable !== (i % 6 == 4)) begin bad++; $display("FAIL arb_en c%0d got=%b%b", i, o_WEnable, o_REnable); end
      if (i == 6) begin
        total++; if (o_M1_RData !== 32'hBEEF) begin bad++; $display("FAIL arb_m1_rdata got=%h exp=beef", o_M1_RData); end
      end
    end
    i_M0_Req = 0; i_M1_Req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({o_M0_Ack, o_M1_Ack, o_WEnable, o_REnable} !== 4'b0) begin bad++; $display("FAIL arb_quiet c%0d got=%b exp=0000", i, {o_M0_Ack, o_M1_Ack, o_WEnable, o_REnable}); end
    end
  endtask

  task automatic test_error();
    i_M0_Req = 1; i_M0_Wr = 1; i_M0_Addr = 32'd3; i_M0_WData = 32'h99; i_Err = 1;
    tick(); tick(); tick();
    total++; if (o_M0_Ack !== 1'b1 || o_M0_Err !== 1'b1) begin bad++; $display("FAIL err_wr got ack=%b err=%b exp ack=1 err=1", o_M0_Ack, o_M0_Err); end
    total++; if (o_M1_RData !== 32'hBEEF || o_M1_Err !== 1'b0) begin bad++; $display("FAIL err_nonowner_hold got=%h/%b exp=beef/0", o_M1_RData, o_M1_Err); end
    i_M0_Wr = 0; i_M0_Addr = 32'd0; i_Err = 0; i_RData = 32'h77;
    tick();
    total++; if ({o_REnable, o_RAddr} !== {1'b1, 32'd0}) begin bad++; $display("FAIL err_rd_issue got=%b/%h exp=1/0", o_REnable, o_RAddr); end
    tick(); tick();
    total++; if (o_M0_Ack !== 1'b1 || o_M0_Err !== 1'b0 || o_M0_RData !== 32'h77) begin bad++; $display("FAIL err_rd got ack=%b err=%b rdata=%h exp 1/0/77", o_M0_Ack, o_M0_Err, o_M0_RData); end
    i_M0_Req = 0;
    tick();
  endtask

  task automatic test_drop_after_grant();
    int acks = 0;
    int ens = 0;
    i_M1_Req = 1; i_M1_Wr = 0; i_M1_Addr = 32'd5; i_RData = 32'h1234;
    tick();
    total++; if (o_Grant !== 2'b10) begin bad++; $display("FAIL drop_grant got=%b exp=10", o_Grant); end
    i_M1_Req = 0;
    if (o_REnable) ens++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_M1_Ack) acks++;
      if (o_REnable || o_WEnable) ens++;
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL drop_ack_count got=%0d exp=1", acks); end
    total++; if (ens !== 1) begin bad++; $display("FAIL drop_issue_count got=%0d exp=1", ens); end
    total++; if (o_M1_RData !== 32'h1234) begin bad++; $display("FAIL drop_rdata got=%h exp=1234", o_M1_RData); end
  endtask

  task automatic test_reset_mid_issue();
    int acks = 0;
    i_M0_Req = 1; i_M0_Wr = 1; i_M0_Addr = 32'd7; i_M0_WData = 32'hAB;
    tick();
    total++; if (o_WEnable !== 1'b1) begin bad++; $display("FAIL rst_pre_issue got=%b exp=1", o_WEnable); end
    #2;
    i_Rst_n = 1'b0;
    #1;
    total++; if ({o_WEnable, o_REnable, o_Grant} !== 4'b0) begin bad++; $display("FAIL rst_async got=%b exp=0000", {o_WEnable, o_REnable, o_Grant}); end
    total++; if ({o_WAddr, o_WData, o_M0_RData, o_M0_Err} !== 97'd0) begin bad++; $display("FAIL rst_async_data got=%h exp=0", {o_WAddr, o_WData, o_M0_RData, o_M0_Err}); end
    i_M0_Req = 0;
    tick();
    i_Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_M0_Ack || o_M1_Ack || o_WEnable || o_REnable) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL rst_no_ack got=%0d exp=0", acks); end
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_arbitration();
    test_error();
    test_drop_after_grant();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Two-master, round-robin arbiter that shares one simple-bus slave port (the write/read-enable register bus used by the GPIO slave and sibling peripherals) between two requesters, e.g. the CPU load/store unit and a DMA engine. Each master posts a single read or write and holds it until a one-cycle acknowledge returns the slave's read data and error flag. The block sequences the slave's one-cycle-registered response and guarantees one outstanding transaction on the slave at a time.

## Interface
- ADDR_W, 32, address width on master and slave sides
- DATA_W, 32, data width on master and slave sides

- i_Clk  in  1  clock, all state on rising edge
- i_Rst_n  in  1  reset, asynchronous, active-low
- i_M0_Req / i_M1_Req  in  1  master request, held until ack
- i_M0_Wr / i_M1_Wr  in  1  1 = write, 0 = read
- i_M0_Addr / i_M1_Addr  in  ADDR_W  transaction address
- i_M0_WData / i_M1_WData  in  DATA_W  write data
- o_M0_Ack / o_M1_Ack  out  1  one-cycle completion pulse
- o_M0_RData / o_M1_RData  out  DATA_W  read data, valid with ack
- o_M0_Err / o_M1_Err  out  1  slave error, valid with ack
- o_WEnable  out  1  slave write strobe
- o_WAddr / o_WData  out  ADDR_W / DATA_W  slave write address/data
- o_REnable  out  1  slave read strobe
- o_RAddr  out  ADDR_W  slave read address
- i_RData  in  DATA_W  slave read data (registered in slave)
- i_Err  in  1  slave error flag (registered in slave)
- o_Grant  out  2  one-hot owner of current transaction, 0 when idle

## Operation
- FSM states: IDLE, ISSUE, RESP. All outputs registered.
- IDLE: if any Req high, select winner, latch its Wr/Addr/WData, set o_Grant, go ISSUE; else stay.
- Arbitration: single requester wins; both requesting -> master not granted last (pointer `last`). Pointer updates on each grant. Reset value of `last` = 1, so M0 wins the first tie.
- ISSUE (exactly one cycle): write -> o_WEnable=1, o_WAddr/o_WData = latched; read -> o_REnable=1, o_RAddr = latched. Never both enables. Go RESP.
- RESP (one cycle): sample i_Err and, for reads, i_RData into the owner's o_Mx_RData/o_Mx_Err; for writes o_Mx_RData <= 0. Assert owner's o_Mx_Ack for the next cycle, go IDLE, clear o_Grant.
- Non-owner Ack always 0; non-owner RData/Err hold previous values.
- Req seen high in IDLE (including the Ack cycle) is a new transaction: master holding Req through Ack issues back-to-back.
- Req dropped by a master before grant: no transaction. Req dropped after grant: transaction completes, ack still issued.
- Enables deasserted in every state except ISSUE; slave address/data outputs hold last value.

## Timing
- Reset (async assert, sync release): state IDLE, all Ack/enables 0, o_Grant 0, all RData/Addr/WData outputs 0, all Err 0, `last` = 1.
- Req high in cycle N (IDLE) -> enable high in N+1 -> slave updates at end of N+1 -> arbiter samples in N+2 -> o_Mx_Ack high in N+3.
- Latency 3 cycles from Req to Ack; throughput 1 transaction per 3 cycles per slave.
- Reset asserted mid-transaction: abandoned immediately, no Ack produced, enables drop asynchronously.
- Slave i_Err=1 on write to invalid address: returned as o_Mx_Err=1 with Ack; arbiter state unaffected.

## Test plan
- Reset: drive i_Rst_n=0 mid-ISSUE with o_WEnable=1 -> all outputs 0 asynchronously, no Ack after release.
- M0 write Addr=1, WData=0x5A -> o_WEnable=1 with o_WAddr=1, o_WData=0x5A one cycle after Req, o_M0_Ack pulse 3 cycles after Req, o_M0_Err=0, o_M0_RData=0.
- M1 read Addr=2, slave i_RData=0x0000000C -> o_REnable=1, o_RAddr=2, o_M1_Ack with o_M1_RData=0x0C, o_M1_Err=0.
- Both masters request at once after reset, both hold Req -> grant order M0, M1, M0, M1; each Ack 3 cycles apart; never two enables or two Acks together.
- M0 write Addr=3 with slave i_Err=1 -> o_M0_Err=1 with Ack; next M0 read Addr=0 -> o_M0_Err=0.
- M1 raises Req, drops it one cycle after grant -> transaction still issued, o_M1_Ack still pulses once.
